shf_d4c3: RTL and testbench



---
 rtl/shf_d4c3.sv | 46 ++++
 tb/tb_shf_d4c3.sv | 122 ++++++++++++
 2 files changed

// File: rtl/shf_d4c3.sv
// shf_d4c3: 4-bit shifter/rotator with a registered result and a one-cycle valid strobe
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset (clears y and out_valid)
//   d[3:0]    operand, sampled when in_valid is high
//   s[2:0]    operation select: pass/SLL1/SRL1/SRA1/ROL1/ROR1/ROL2/clear
//   in_valid  sample strobe
//   y[3:0]    result, one cycle after the accepted sample; holds otherwise
//   out_valid high for one cycle after each accepted sample
module shf_d4c3 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] d,
  input  logic [2:0] s,
  input  logic       in_valid,
  output logic [3:0] y,
  output logic       out_valid
);
  logic [3:0] y_q, y_d, r;
  logic       v_q;
  always_comb begin
    r = 4'b0000;
    case (s)
      3'b000: r = d;
      3'b001: r = {d[2:0], 1'b0};
      3'b010: r = {1'b0, d[3:1]};
      3'b011: r = {d[3], d[3:1]};
      3'b100: r = {d[2:0], d[3]};
      3'b101: r = {d[0], d[3:1]};
      3'b110: r = {d[1:0], d[3:2]};
      default: r = 4'b0000;
    endcase
  end
  // y keeps its last result while no sample is accepted
  always_comb y_d = in_valid ? r : y_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q <= 4'b0000;
      v_q <= 1'b0;
    end else begin
      y_q <= y_d;
      v_q <= in_valid;
    end
  end
  assign y = y_q;
  assign out_valid = v_q;
endmodule

// File: tb/tb_shf_d4c3.sv
// tb_shf_d4c3: directed self-checking bench for shf_d4c3
module tb_shf_d4c3;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] d = 4'b0000;
  logic [2:0] s = 3'b000;
  logic [3:0] y;
  logic       out_valid;
  int n = 0;
  int errs = 0;
  logic [3:0] sweep [8] = '{4'b1011, 4'b0110, 4'b0101, 4'b1101, 4'b0111, 4'b1101, 4'b1110, 4'b0000};

  always #5 clk = ~clk;

  shf_d4c3 dut (
    .clk(clk),
    .rst_n(rst_n),
    .d(d),
    .s(s),
    .in_valid(in_valid),
    .y(y),
    .out_valid(out_valid)
  );

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic [3:0] dd, input logic [2:0] ss);
    in_valid = v;
    d = dd;
    s = ss;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] ref_r(input logic [3:0] a, input logic [2:0] op);
    int x;
    int r;
    x = int'(a);
    case (op)
      3'd0: r = x;
      3'd1: r = (x << 1) & 15;
      3'd2: r = x >> 1;
      3'd3: r = (x >> 1) | (x & 8);
      3'd4: r = ((x << 1) | (x >> 3)) & 15;
      3'd5: r = ((x >> 1) | (x << 3)) & 15;
      3'd6: r = ((x << 2) | (x >> 2)) & 15;
      default: r = 0;
    endcase
    return 4'(r);
  endfunction

  initial begin
    #2;
    chk("por_y", y, 4'b0000);
    chk("por_v", {3'b000, out_valid}, 4'b0000);
    step(1'b1, 4'b1111, 3'b000);
    chk("rst_wins_y", y, 4'b0000);
    chk("rst_wins_v", {3'b000, out_valid}, 4'b0000);
    rst_n = 1'b1;
    step(1'b1, 4'b1010, 3'b000);
    chk("pre_rst_y", y, 4'b1010);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_y", y, 4'b0000);
    chk("async_rst_v", {3'b000, out_valid}, 4'b0000);
    step(1'b1, 4'b0101, 3'b001);
    chk("rst_held_y", y, 4'b0000);
    chk("rst_held_v", {3'b000, out_valid}, 4'b0000);
    rst_n = 1'b1;
    step(1'b0, 4'b0101, 3'b001);
    chk("post_rel_y", y, 4'b0000);
    chk("post_rel_v", {3'b000, out_valid}, 4'b0000);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 4'b1011, 3'(i));
      chk($sformatf("sweep_s%0d", i), y, sweep[i]);
      chk($sformatf("sweep_v%0d", i), {3'b000, out_valid}, 4'b0001);
    end
    step(1'b1, 4'b1000, 3'b011);
    chk("sra_sign", y, 4'b1100);
    step(1'b1, 4'b1000, 3'b100);
    chk("rol_wrap", y, 4'b0001);
    step(1'b1, 4'b0001, 3'b101);
    chk("ror_wrap", y, 4'b1000);
    step(1'b1, 4'b0001, 3'b010);
    chk("srl_out", y, 4'b0000);
    for (int i = 0; i < 128; i++) begin
      step(1'b1, 4'(i), 3'(7 + i / 16));
      chk($sformatf("exh_%0d", i), y, ref_r(4'(i), 3'(7 + i / 16)));
    end
    chk("exh_v", {3'b000, out_valid}, 4'b0001);
    step(1'b1, 4'b0110, 3'b001);
    chk("hold_load", y, 4'b1100);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 4'($urandom), 3'($urandom));
      chk($sformatf("hold_y%0d", i), y, 4'b1100);
      chk($sformatf("hold_v%0d", i), {3'b000, out_valid}, 4'b0000);
    end
    step(1'b1, 4'b0011, 3'b100);
    chk("mid_a", y, 4'b0110);
    in_valid = 1'b1;
    d = 4'b0101;
    s = 3'b001;
    #1 rst_n = 1'b0;
    #4;
    chk("mid_rst_y", y, 4'b0000);
    chk("mid_rst_v", {3'b000, out_valid}, 4'b0000);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_b_y", y, 4'b1010);
    chk("mid_b_v", {3'b000, out_valid}, 4'b0001);
    $display("== %0d vectors applied, %0d miscompares ==", n, errs);
    $finish;
  end
endmodule
